// File: rtl/writeback_queue_pkg.sv
// Shared CPU definitions for the writeback stage: source/load encodings and
// the hard-wired zero register.
package writeback_queue_pkg;

  typedef enum logic [1:0] {
    WB_SRC_RESULT = 2'b00,
    WB_SRC_MEM    = 2'b01,
    WB_SRC_PC8    = 2'b10,
    WB_SRC_RSVD   = 2'b11
  } wb_src_e;

  typedef enum logic [2:0] {
    WB_LD_WORD = 3'b000,
    WB_LD_LBU  = 3'b001,
    WB_LD_LB   = 3'b010,
    WB_LD_LHU  = 3'b011,
    WB_LD_LH   = 3'b100
  } wb_ld_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A write to the zero register never happens.
  function automatic logic reg_write(input logic valid, input logic [4:0] addr);
    return valid && (addr != REG_ZERO);
  endfunction

endpackage

// File: rtl/writeback_queue_if.sv
// Long-latency (mul/div/HI-LO) result channel: valid/ready handshake with
// destination register and data.
interface writeback_queue_if #(
  parameter int DATA_W = 32
);
  logic              md_valid;
  logic              md_ready;
  logic [4:0]        md_addr;
  logic [DATA_W-1:0] md_data;

  modport master (output md_valid, output md_addr, output md_data, input md_ready);
  modport slave  (input md_valid, input md_addr, input md_data, output md_ready);
endinterface

// File: rtl/wb_load_ext.sv
// Load alignment and extension: picks the byte/half addressed by the low
// address bits out of the raw memory word and zero/sign-extends it.
module wb_load_ext
  import writeback_queue_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rd_i,
  input  logic [1:0]        off_i,
  input  logic [2:0]        ld_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select (halves use only bit 1 of the offset) then extension.
  always_comb begin
    byte_sel = '0;
    case (off_i)
      2'd0:    byte_sel = rd_i[7:0];
      2'd1:    byte_sel = rd_i[15:8];
      2'd2:    byte_sel = rd_i[23:16];
      default: byte_sel = rd_i[31:24];
    endcase
    half_sel = off_i[1] ? rd_i[31:16] : rd_i[15:0];
    data_o   = rd_i;
    case (ld_i)
      WB_LD_LBU: data_o = {{(DATA_W-8){1'b0}}, byte_sel};
      WB_LD_LB:  data_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      WB_LD_LHU: data_o = {{(DATA_W-16){1'b0}}, half_sel};
      WB_LD_LH:  data_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
      default:   data_o = rd_i;
    endcase
  end

endmodule

// File: rtl/writeback_queue.sv
// Register-file writeback arbiter: the pipeline WB slot has absolute priority;
// long-latency results wait in a small FIFO and drain in idle WB cycles.
// Queued entries overwritten by a younger pipeline write are killed in place.
module writeback_queue
  import writeback_queue_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_valid,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_result,
  input  logic [DATA_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_pc8,
  input  logic [1:0]        wb_src,
  input  logic [2:0]        wb_ld,
  writeback_queue_if.slave  md,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  output logic              hz_stall,
  output logic              starve_stall,
  output logic              rf_we,
  output logic [4:0]        rf_addr,
  output logic [DATA_W-1:0] rf_wd
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]        q_addr_q [QDEPTH];
  logic [DATA_W-1:0] q_data_q [QDEPTH];
  logic              q_vld_q  [QDEPTH];
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]     occ_q;
  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
  logic              starve_stall_q, starve_stall_d;
  logic              rf_we_q;
  logic [4:0]        rf_addr_q;
  logic [DATA_W-1:0] rf_wd_q;

  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] pipe_wd;
  logic              pipe_we;
  logic              q_empty, q_full, head_vld;
  logic              pop, md_acc, md_live, bypass, push, push_vld, head_blocked;

  wb_load_ext #(.DATA_W(DATA_W)) u_load_ext (
    .rd_i   (wb_rd),
    .off_i  (wb_result[1:0]),
    .ld_i   (wb_ld),
    .data_o (load_data)
  );

  // Pipeline write data source select; reserved encoding falls back to result.
  always_comb begin
    pipe_wd = wb_result;
    case (wb_src)
      WB_SRC_MEM: pipe_wd = load_data;
      WB_SRC_PC8: pipe_wd = wb_pc8;
      default:    pipe_wd = wb_result;
    endcase
  end

  // Arbitration and handshake; a full queue can still accept when its head pops.
  always_comb begin
    pipe_we      = reg_write(wb_valid, wb_addr);
    q_empty      = (occ_q == '0);
    q_full       = (occ_q == CW'(QDEPTH));
    head_vld     = q_vld_q[rd_ptr_q];
    pop          = !q_empty && !pipe_we;
    md.md_ready  = !q_full || pop;
    md_acc       = md.md_valid && md.md_ready;
    md_live      = md_acc && (md.md_addr != REG_ZERO);
    bypass       = md_live && q_empty && !pipe_we;
    push         = md_live && !bypass;
    // An md beat is program-older than the pipeline write, so same-register
    // beats enter the queue already killed.
    push_vld     = !(pipe_we && (md.md_addr == wb_addr));
    head_blocked = !q_empty && head_vld && pipe_we;
  end

  // Decode hazard: any live queued destination or an incoming beat matches rs/rt.
  always_comb begin
    hz_stall = 1'b0;
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      if (q_vld_q[i] && (q_addr_q[i] != REG_ZERO) &&
          ((q_addr_q[i] == rs_addr) || (q_addr_q[i] == rt_addr)))
        hz_stall = 1'b1;
    end
    if (md_live && ((md.md_addr == rs_addr) || (md.md_addr == rt_addr)))
      hz_stall = 1'b1;
  end

  // Starvation counter: pulses once when the head has been blocked STARVE_MAX cycles.
  always_comb begin
    starve_stall_d = 1'b0;
    starve_cnt_d   = '0;
    if (head_blocked)
      starve_cnt_d = starve_cnt_q + 1'b1;
    if (starve_cnt_d == SW'(STARVE_MAX)) begin
      starve_stall_d = 1'b1;
      starve_cnt_d   = '0;
    end
  end

  // Queue control state: pointers, occupancy and per-slot valid (kill) bits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++)
        q_vld_q[i] <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        if (pipe_we && q_vld_q[i] && (q_addr_q[i] == wb_addr))
          q_vld_q[i] <= 1'b0;
      end
      if (pop) begin
        q_vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + 1'b1;
      end
      // Ordered after the pop so a full-and-popping push owns the shared slot.
      if (push) begin
        q_vld_q[wr_ptr_q] <= push_vld;
        wr_ptr_q          <= wr_ptr_q + 1'b1;
      end
      occ_q <= occ_q + CW'(push) - CW'(pop);
    end
  end

  // Queue payload storage; validity is tracked separately so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr_q[wr_ptr_q] <= md.md_addr;
      q_data_q[wr_ptr_q] <= md.md_data;
    end
  end

  // Registered register-file write port and starvation state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we_q        <= 1'b0;
      rf_addr_q      <= '0;
      rf_wd_q        <= '0;
      starve_cnt_q   <= '0;
      starve_stall_q <= 1'b0;
    end else begin
      rf_we_q        <= pipe_we || (pop && head_vld) || bypass;
      starve_cnt_q   <= starve_cnt_d;
      starve_stall_q <= starve_stall_d;
      if (pipe_we) begin
        rf_addr_q <= wb_addr;
        rf_wd_q   <= pipe_wd;
      end else if (pop && head_vld) begin
        rf_addr_q <= q_addr_q[rd_ptr_q];
        rf_wd_q   <= q_data_q[rd_ptr_q];
      end else if (bypass) begin
        rf_addr_q <= md.md_addr;
        rf_wd_q   <= md.md_data;
      end
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_addr      = rf_addr_q;
  assign rf_wd        = rf_wd_q;
  assign starve_stall = starve_stall_q;

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: load-extension vector table, directed corner
// sequences and a randomized run against a queue-based reference model.
module tb_writeback_queue;

  localparam int QD = 4;
  localparam int SM = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_result, wb_rd, wb_pc8;
  logic [1:0]  wb_src;
  logic [2:0]  wb_ld;
  logic [4:0]  rs_addr, rt_addr;
  logic        hz_stall, starve_stall, rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wd;

  writeback_queue_if #(.DATA_W(32)) mdif ();

  writeback_queue #(.DATA_W(32), .QDEPTH(QD), .STARVE_MAX(SM)) dut (
    .clk          (clk),
    .reset        (reset),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_result    (wb_result),
    .wb_rd        (wb_rd),
    .wb_pc8       (wb_pc8),
    .wb_src       (wb_src),
    .wb_ld        (wb_ld),
    .md           (mdif.slave),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .hz_stall     (hz_stall),
    .starve_stall (starve_stall),
    .rf_we        (rf_we),
    .rf_addr      (rf_addr),
    .rf_wd        (rf_wd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] res, rd, pc8;
    logic [1:0]  src;
    logic [2:0]  ld;
    logic        mv;
    logic [4:0]  ma;
    logic [31:0] md;
    logic [4:0]  rs, rt;
  } in_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    bit          live;
  } ent_t;

  typedef struct {
    logic        wv;
    logic [4:0]  wa;
    logic [1:0]  src;
    logic [2:0]  ld;
    logic [31:0] res, rd, pc8;
    logic        exp_we;
    logic [31:0] exp_wd;
  } vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  ent_t mq[$];
  int   streak = 0;
  logic s_hz, s_rdy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Writeback data derived from the ISA rules by shifting and masking.
  function automatic logic [31:0] ref_wd(input in_t v);
    logic [31:0] w;
    int sb, sh;
    sb = 8 * int'(v.res[1:0]);
    sh = 16 * int'(v.res[1]);
    case (v.src)
      2'b01: begin
        case (v.ld)
          3'b001: w = (v.rd >> sb) & 32'hFF;
          3'b010: begin w = (v.rd >> sb) & 32'hFF;   if (w[7])  w = w | 32'hFFFF_FF00; end
          3'b011: w = (v.rd >> sh) & 32'hFFFF;
          3'b100: begin w = (v.rd >> sh) & 32'hFFFF; if (w[15]) w = w | 32'hFFFF_0000; end
          default: w = v.rd;
        endcase
      end
      2'b10:   w = v.pc8;
      default: w = v.res;
    endcase
    return w;
  endfunction

  function automatic in_t idle_in();
    in_t v;
    v = '{wv: 1'b0, wa: 5'd0, res: 32'd0, rd: 32'd0, pc8: 32'd0, src: 2'd0, ld: 3'd0,
          mv: 1'b0, ma: 5'd0, md: 32'd0, rs: 5'd0, rt: 5'd0};
    return v;
  endfunction

  task automatic drive(input in_t v);
    wb_valid = v.wv; wb_addr = v.wa; wb_result = v.res; wb_rd = v.rd; wb_pc8 = v.pc8;
    wb_src = v.src; wb_ld = v.ld; mdif.md_valid = v.mv; mdif.md_addr = v.ma;
    mdif.md_data = v.md; rs_addr = v.rs; rt_addr = v.rt;
  endtask

  // One clock: drive, check combinational outputs, advance model, check registers.
  task automatic step(input in_t v, output logic hz_s, output logic rdy_s);
    bit pwe, rdy, acc_live, hz, blocked, bypassed, ewe;
    logic [4:0] ea;
    logic [31:0] ed;
    ent_t e;
    bit est;
    drive(v);
    #1;
    hz_s = hz_stall;
    rdy_s = mdif.md_ready;
    pwe = v.wv && (v.wa != 0);
    rdy = (mq.size() < QD) || (mq.size() > 0 && !pwe);
    acc_live = v.mv && rdy && (v.ma != 0);
    hz = acc_live && ((v.ma == v.rs) || (v.ma == v.rt));
    foreach (mq[i]) if (mq[i].live && ((mq[i].a == v.rs) || (mq[i].a == v.rt))) hz = 1;
    chk("md_ready", 32'(mdif.md_ready), 32'(rdy));
    chk("hz_stall", 32'(hz_stall), 32'(hz));
    blocked = (mq.size() > 0) && mq[0].live && pwe;
    bypassed = 0; ewe = 0; ea = 0; ed = 0;
    if (pwe) begin
      ewe = 1; ea = v.wa; ed = ref_wd(v);
      foreach (mq[i]) if (mq[i].a == v.wa) mq[i].live = 0;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      ewe = e.live; ea = e.a; ed = e.d;
    end else if (acc_live) begin
      ewe = 1; ea = v.ma; ed = v.md; bypassed = 1;
    end
    if (acc_live && !bypassed)
      mq.push_back('{a: v.ma, d: v.md, live: !(pwe && v.ma == v.wa)});
    streak = blocked ? streak + 1 : 0;
    est = (streak == SM);
    if (est) streak = 0;
    @(posedge clk);
    #1;
    chk("rf_we", 32'(rf_we), 32'(ewe));
    if (ewe) begin
      chk("rf_addr", 32'(rf_addr), 32'(ea));
      chk("rf_wd", rf_wd, ed);
    end
    chk("starve_stall", 32'(starve_stall), 32'(est));
  endtask

  task automatic pipe_md(input logic [4:0] wa, input logic [4:0] ma, input logic [31:0] md);
    in_t v;
    v = idle_in();
    v.wv = 1; v.wa = wa; v.res = 32'h1000 + 32'(wa);
    v.mv = 1; v.ma = ma; v.md = md;
    step(v, s_hz, s_rdy);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(idle_in(), s_hz, s_rdy);
  endtask

  vec_t vt[16];
  in_t  v;

  initial begin
    vt[0]  = '{1, 5'd1,  2'b00, 3'd0, 32'h1234_5678, 32'h8001_7FF0, 32'hDEAD_BEEF, 1, 32'h1234_5678};
    vt[1]  = '{1, 5'd2,  2'b10, 3'd0, 32'h1234_5678, 32'h8001_7FF0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF};
    vt[2]  = '{1, 5'd3,  2'b11, 3'd0, 32'h1234_5678, 32'h8001_7FF0, 32'hDEAD_BEEF, 1, 32'h1234_5678};
    vt[3]  = '{1, 5'd4,  2'b01, 3'd0, 32'h0000_0000, 32'h8001_7FF0, 32'h0,         1, 32'h8001_7FF0};
    vt[4]  = '{1, 5'd5,  2'b01, 3'd1, 32'h0000_0000, 32'h8001_7FF0, 32'h0,         1, 32'h0000_00F0};
    vt[5]  = '{1, 5'd6,  2'b01, 3'd2, 32'h0000_0000, 32'h8001_7FF0, 32'h0,         1, 32'hFFFF_FFF0};
    vt[6]  = '{1, 5'd7,  2'b01, 3'd2, 32'h0000_0001, 32'h8001_7FF0, 32'h0,         1, 32'h0000_007F};
    vt[7]  = '{1, 5'd8,  2'b01, 3'd1, 32'h0000_0003, 32'h8001_7FF0, 32'h0,         1, 32'h0000_0080};
    vt[8]  = '{1, 5'd9,  2'b01, 3'd2, 32'h0000_0003, 32'h8001_7FF0, 32'h0,         1, 32'hFFFF_FF80};
    vt[9]  = '{1, 5'd10, 2'b01, 3'd3, 32'h0000_0002, 32'h8001_7FF0, 32'h0,         1, 32'h0000_8001};
    vt[10] = '{1, 5'd11, 2'b01, 3'd4, 32'h0000_0002, 32'h8001_7FF0, 32'h0,         1, 32'hFFFF_8001};
    vt[11] = '{1, 5'd12, 2'b01, 3'd4, 32'h0000_0000, 32'h8001_7FF0, 32'h0,         1, 32'h0000_7FF0};
    vt[12] = '{1, 5'd13, 2'b01, 3'd7, 32'h0000_0001, 32'h8001_7FF0, 32'h0,         1, 32'h8001_7FF0};
    vt[13] = '{1, 5'd14, 2'b01, 3'd2, 32'h0000_0003, 32'h80FF_0000, 32'h0,         1, 32'hFFFF_FF80};
    vt[14] = '{1, 5'd15, 2'b01, 3'd4, 32'h0000_0001, 32'h8001_7FF0, 32'h0,         1, 32'h0000_7FF0};
    vt[15] = '{1, 5'd0,  2'b00, 3'd0, 32'h5555_5555, 32'h0,         32'h0,         0, 32'h0};

    reset = 1'b0;
    drive(idle_in());
    #1;
    chk("reset rf_we", 32'(rf_we), 32'd0);
    chk("reset rf_addr", 32'(rf_addr), 32'd0);
    chk("reset rf_wd", rf_wd, 32'd0);
    chk("reset starve", 32'(starve_stall), 32'd0);
    chk("reset md_ready", 32'(mdif.md_ready), 32'd1);
    chk("reset hz_stall", 32'(hz_stall), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      v = idle_in();
      v.wv = vt[i].wv; v.wa = vt[i].wa; v.src = vt[i].src; v.ld = vt[i].ld;
      v.res = vt[i].res; v.rd = vt[i].rd; v.pc8 = vt[i].pc8;
      step(v, s_hz, s_rdy);
      chk($sformatf("vec%0d we", i), 32'(rf_we), 32'(vt[i].exp_we));
      if (vt[i].exp_we) chk($sformatf("vec%0d wd", i), rf_wd, vt[i].exp_wd);
    end

    // Empty queue, idle pipeline: md beat bypasses straight to rf.
    v = idle_in(); v.mv = 1; v.ma = 5'd3; v.md = 32'hB0B0_0003;
    step(v, s_hz, s_rdy);
    chk("bypass addr", 32'(rf_addr), 32'd3);

    // Fill the queue under continuous pipeline writes, then drain in order.
    for (int i = 0; i < 4; i++) pipe_md(5'd20, 5'(i + 1), 32'hA000_0000 + 32'(i));
    v = idle_in(); v.wv = 1; v.wa = 5'd21; v.mv = 1; v.ma = 5'd6; v.md = 32'hFFFF_FFFF;
    step(v, s_hz, s_rdy);
    chk("full md_ready", 32'(s_rdy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(idle_in(), s_hz, s_rdy);
      chk("drain order", 32'(rf_addr), 32'(i + 1));
      chk("drain data", rf_wd, 32'hA000_0000 + 32'(i));
    end
    idle_cycles(1);

    // Kill: queued $5 overwritten by the pipeline, later pop writes nothing.
    pipe_md(5'd20, 5'd5, 32'hAAAA_0005);
    v = idle_in(); v.wv = 1; v.wa = 5'd5; v.res = 32'h0000_5555;
    step(v, s_hz, s_rdy);
    chk("kill wd", rf_wd, 32'h0000_5555);
    step(idle_in(), s_hz, s_rdy);
    chk("kill pop we", 32'(rf_we), 32'd0);

    // Hazard on a queued register; zero register never stalls.
    pipe_md(5'd20, 5'd9, 32'h9999_0009);
    v = idle_in(); v.wv = 1; v.wa = 5'd21; v.rs = 5'd9;
    step(v, s_hz, s_rdy);
    chk("hz queued $9", 32'(s_hz), 32'd1);
    v = idle_in(); v.wv = 1; v.wa = 5'd22; v.rs = 5'd0; v.rt = 5'd3; v.mv = 1; v.ma = 5'd0;
    step(v, s_hz, s_rdy);
    chk("hz zero reg", 32'(s_hz), 32'd0);
    idle_cycles(2);

    // Starvation: head blocked for SM consecutive pipeline writes.
    pipe_md(5'd20, 5'd7, 32'h7777_0007);
    for (int i = 0; i < SM; i++) begin
      v = idle_in(); v.wv = 1; v.wa = 5'd21; v.res = 32'(i);
      step(v, s_hz, s_rdy);
    end
    chk("starve pulse", 32'(starve_stall), 32'd1);
    step(idle_in(), s_hz, s_rdy);
    chk("starve pop addr", 32'(rf_addr), 32'd7);
    chk("starve one-shot", 32'(starve_stall), 32'd0);

    // Reset mid-operation with three queued entries.
    for (int i = 0; i < 3; i++) pipe_md(5'd20, 5'(11 + i), 32'hC000_0000 + 32'(i));
    drive(idle_in());
    #1;
    reset = 1'b0;
    #1;
    chk("async reset rf_we", 32'(rf_we), 32'd0);
    chk("async reset md_ready", 32'(mdif.md_ready), 32'd1);
    mq.delete();
    streak = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle_cycles(4);

    // Randomized traffic over a small register range to force collisions.
    for (int i = 0; i < 400; i++) begin
      v.wv = ($urandom_range(0, 9) < 6);
      v.wa = 5'($urandom_range(0, 7));
      v.res = $urandom; v.rd = $urandom; v.pc8 = $urandom;
      v.src = 2'($urandom_range(0, 3));
      v.ld = 3'($urandom_range(0, 7));
      v.mv = $urandom_range(0, 1) == 1;
      v.ma = 5'($urandom_range(0, 7));
      v.md = $urandom;
      v.rs = 5'($urandom_range(0, 7));
      v.rt = 5'($urandom_range(0, 7));
      step(v, s_hz, s_rdy);
    end
    // Long pipeline burst to exercise starvation under random state.
    pipe_md(5'd20, 5'd6, 32'h6666_0006);
    for (int i = 0; i < 2 * SM + 3; i++) begin
      v = idle_in(); v.wv = 1; v.wa = 5'd21;
      step(v, s_hz, s_rdy);
    end
    idle_cycles(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
